// File: rtl/sha256_padder.sv
// sha256_padder
//   Turns a byte stream into SHA-256 message blocks. Bytes are packed
//   big-endian into a 512-bit buffer; the closing 0x80 marker and the
//   64-bit big-endian bit-length are appended. When they do not fit in
//   the final data block, one extra block is emitted back-to-back.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   in_valid   : in_data holds a message byte
//   in_ready   : padder accepts a byte this cycle
//   in_data    : message byte
//   in_last    : final byte of the message (qualified by in_valid)
//   blk_valid  : blk_data holds a complete block
//   blk_ready  : core accepts the block this cycle
//   blk_data   : block, byte 0 at [511:504], byte 63 at [7:0]
//   blk_first  : first block of a message (qualified by blk_valid)
//   blk_last   : final block of a message (qualified by blk_valid)
//
// state  | meaning
// ACCEPT | collecting message bytes into the buffer
// SEND   | presenting a finished block to the core

module sha256_padder #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic {ACCEPT, SEND} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LEN, PEND_PAD80} pend_t;

  state_t             state, state_nxt;
  pend_t              pending;
  logic [511:0]       blk_buf;
  logic [511:0]       acc_buf;
  logic [5:0]         idx;
  logic [5:0]         idx_p1;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               first_q;
  logic               last_q;
  logic               in_fire;
  logic               blk_fire;

  // Message bit count as a 64-bit big-endian field.
  function automatic logic [63:0] len_field(input logic [CNT_W-1:0] cnt);
    logic [63:0] f;
    f = '0;
    f[CNT_W+2:3] = cnt;
    return f;
  endfunction

  assign in_ready  = (state == ACCEPT);
  assign blk_valid = (state == SEND);
  assign in_fire   = in_valid && in_ready;
  assign blk_fire  = blk_valid && blk_ready;
  assign cnt_inc   = byte_cnt + 1'b1;
  assign idx_p1    = idx + 1'b1;

  assign blk_data  = blk_buf;
  assign blk_first = blk_valid && first_q;
  assign blk_last  = blk_valid && last_q;

  // Buffer contents after accepting the current byte. {~idx,3'b000} is
  // the bit offset of byte idx counted from the MSB end.
  always_comb begin
    acc_buf = blk_buf;
    acc_buf[{~idx, 3'b000} +: 8] = in_data;
    if (in_last) begin
      if (idx != 6'd63)
        acc_buf[{~idx_p1, 3'b000} +: 8] = 8'h80;
      if (idx <= 6'd54)
        acc_buf[63:0] = len_field(cnt_inc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCEPT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT: if (in_fire && (in_last || idx == 6'd63)) state_nxt = SEND;
      SEND:   if (blk_fire && pending == PEND_NONE)     state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_buf  <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      pending  <= PEND_NONE;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
    end else if (state == ACCEPT) begin
      if (in_fire) begin
        blk_buf  <= acc_buf;
        idx      <= idx_p1;
        byte_cnt <= cnt_inc;
        last_q   <= 1'b0;
        pending  <= PEND_NONE;
        if (in_last) begin
          if (idx <= 6'd54)       last_q  <= 1'b1;
          else if (idx != 6'd63)  pending <= PEND_LEN;
          else                    pending <= PEND_PAD80;
        end
      end
    end else if (blk_fire) begin
      case (pending)
        PEND_LEN: begin
          blk_buf <= {448'b0, len_field(byte_cnt)};
          last_q  <= 1'b1;
          first_q <= 1'b0;
          pending <= PEND_NONE;
        end
        PEND_PAD80: begin
          blk_buf <= {8'h80, 440'b0, len_field(byte_cnt)};
          last_q  <= 1'b1;
          first_q <= 1'b0;
          pending <= PEND_NONE;
        end
        default: begin
          blk_buf <= '0;
          idx     <= '0;
          last_q  <= 1'b0;
          if (last_q) begin
            byte_cnt <= '0;
            first_q  <= 1'b1;
          end else begin
            first_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  sha256_padder #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] msg[$];
  int         nvec = 0;
  int         errs = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a block transfers on the next rising edge.
  always @(negedge clk) begin
    if (!reset && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL unexpected_block got=%0h", blk_data);
      end else begin
        blk_t e;
        e = exp_q.pop_front();
        check("blk_data",  blk_data, e.data);
        check("blk_first", 512'(blk_first), 512'(e.first));
        check("blk_last",  512'(blk_last),  512'(e.last));
      end
    end
  end

  // Reference SHA-256 padding of msg into expected blocks.
  task automatic push_model();
    logic [7:0]  b[$];
    logic [63:0] bits;
    int          nblk;
    b = msg;
    bits = 64'(msg.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bits[i*8 +: 8]);
    nblk = b.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      blk_t e;
      for (int j = 0; j < 64; j++) e.data[(63-j)*8 +: 8] = b[k*64 + j];
      e.first = (k == 0);
      e.last  = (k == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_lit(input logic [511:0] d, input logic f, input logic l);
    blk_t e;
    e.data = d; e.first = f; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      n++;
      if (n > 500) begin
        nvec++;
        errs++;
        $display("FAIL accept_timeout got=in_ready_low expected=accept");
        return;
      end
    end
  endtask

  task automatic send_msg(input bit with_last);
    for (int i = 0; i < msg.size(); i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == msg.size() - 1);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic set_abc();
    msg = {8'h61, 8'h62, 8'h63};
  endtask

  task automatic set_pattern(input int n, input int seed);
    msg = {};
    for (int i = 0; i < n; i++) msg.push_back(8'((i * 7 + seed) & 8'hFF));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("queue_drained", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  512'(in_ready),  512'(1));
    check("rst_blk_valid", 512'(blk_valid), 512'(0));
    check("rst_blk_data",  blk_data,        512'(0));
    check("rst_blk_first", 512'(blk_first), 512'(0));
    check("rst_blk_last",  512'(blk_last),  512'(0));
    reset = 1'b0;

    // "abc"
    set_abc();
    push_lit({32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
    send_msg(1'b1);
    drain();

    // 55 zero bytes: padding and length fit in one block
    msg = {};
    for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    push_lit({440'b0, 8'h80, 64'h1B8}, 1'b1, 1'b1);
    send_msg(1'b1);
    drain();

    // 56 bytes: length spills into a second block
    set_pattern(56, 1);
    push_model();
    send_msg(1'b1);
    drain();

    // 63 bytes: 0x80 at byte 63, length block follows
    set_pattern(63, 5);
    push_model();
    send_msg(1'b1);
    drain();

    // 64 bytes: data-only block, then 0x80 + length block
    set_pattern(64, 3);
    push_model();
    send_msg(1'b1);
    drain();

    // 120 bytes: full block then last-byte at index 55
    set_pattern(120, 9);
    push_model();
    send_msg(1'b1);
    drain();

    // Back-pressure: hold blk_ready low in SEND while offering bytes
    set_abc();
    push_lit({32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
    blk_ready = 1'b0;
    send_msg(1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_blk_valid", 512'(blk_valid), 512'(1));
      check("hold_in_ready",  512'(in_ready),  512'(0));
      check("hold_blk_data",  blk_data,        exp_q[0].data);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b1;
    drain();

    // byte count after the stall must not include the offered bytes
    set_pattern(10, 2);
    push_model();
    send_msg(1'b1);
    drain();

    // Reset mid-message, then "abc"
    set_pattern(10, 4);
    send_msg(1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_in_ready", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_abc();
    push_lit({32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
    send_msg(1'b1);
    drain();

    // Reset mid-SEND discards the pending block
    blk_ready = 1'b0;
    set_pattern(64, 6);
    send_msg(1'b0);
    #3;
    check("send_blk_valid", 512'(blk_valid), 512'(1));
    reset = 1'b1;
    #1;
    check("async_rst_blk_valid", 512'(blk_valid), 512'(0));
    check("async_rst_blk_data",  blk_data,        512'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    blk_ready = 1'b1;
    set_abc();
    push_lit({32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
    send_msg(1'b1);
    drain();

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
